// File: rtl/uart_pkg.sv
// Shared UART definitions: word-length encoding, receiver FSM states and
// the default oversampling rate.
package uart_pkg;

  // LCR word-length select encodings
  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // baud_pulse ticks per bit period
  localparam int OS_RATE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  // Number of data bits selected by the word-length field
  function automatic logic [3:0] wls_bits(input logic [1:0] wls);
    logic [3:0] n;
    case (wls)
      WLS_5:   n = 4'd5;
      WLS_6:   n = 4'd6;
      WLS_7:   n = 4'd7;
      WLS_8:   n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line front end: metastability synchroniser, oversampling tick counter
// and mid-bit sampling. Build option RX_MAJORITY_VOTE_EN selects a 2-of-3
// majority over the three ticks ending at the mid-bit point; otherwise a
// single sample is taken at the mid-bit tick. Both give the same bit_valid
// timing.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OS_RATE     = OS_RATE_DEF,  // even, >= 8
  parameter int SYNC_STAGES = 2             // >= 2
) (
  input  logic clk,
  input  logic rst,         // asynchronous, active low
  input  logic baud_pulse,
  input  logic rx,
  input  logic tick_clr,    // hold tick counter at 0 (receiver idle)
  output logic rx_s,
  output logic bit_valid,
  output logic bit_val
);

  localparam int TW = $clog2(OS_RATE);
  localparam logic [TW-1:0] MID  = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OS_RATE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tick_cnt;

  // Synchroniser; presets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Tick counter wraps every bit period, so once aligned at the start bit
  // every later mid-bit point is exactly one bit period after the previous
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            tick_cnt <= '0;
    else if (tick_clr)   tick_cnt <= '0;
    else if (baud_pulse) tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
  end

  assign bit_valid = baud_pulse && !tick_clr && (tick_cnt == MID);

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // Last two tick samples; with the current one they form the vote window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            hist_q <= 2'b11;
    else if (baud_pulse) hist_q <= {hist_q[0], rx_s};
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

endmodule

// File: rtl/uart_rx_top.sv
// 16550-style serial receiver. Frames 5-8 data bits with optional parity,
// checks the first stop bit and delivers each character with pe/fe/bi flags
// on a one-clock push strobe. Build option RX_MAJORITY_VOTE_EN (see
// uart_rx_sampler) enables 2-of-3 majority bit sampling.
//
// Handshake: push is a single-cycle strobe with no ready; the consumer must
// accept dout/pe/fe/bi on the cycle push is high. The values then hold until
// the next push.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int OS_RATE     = OS_RATE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,           // asynchronous, active low
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic [1:0] wls,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       rx_busy,
  output logic [2:0] state_dbg
);

  rx_state_t state, next_state;

  logic       rx_s, bit_valid, bit_val;
  logic       tick_clr, load_cfg, take_data, take_par, take_stop;

  // Frame configuration, frozen at the start edge
  logic       pen_r, eps_r, sticky_r;
  logic [2:0] last_idx_r;

  logic [2:0] bit_cnt;
  logic [7:0] data_r;
  logic       par_err_r;
  logic       zero_r;       // every sampled bit of this frame so far was 0
  logic       exp_par;

  uart_rx_sampler #(
    .OS_RATE     (OS_RATE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .baud_pulse (baud_pulse),
    .rx         (rx),
    .tick_clr   (tick_clr),
    .rx_s       (rx_s),
    .bit_valid  (bit_valid),
    .bit_val    (bit_val)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and per-state control strobes
  always_comb begin
    next_state = state;
    tick_clr   = 1'b0;
    load_cfg   = 1'b0;
    take_data  = 1'b0;
    take_par   = 1'b0;
    take_stop  = 1'b0;
    case (state)
      IDLE: begin
        // Counter held at 0 here, so a tick on the start-detect clock is dropped
        tick_clr = 1'b1;
        if (!rx_s) begin
          next_state = START;
          load_cfg   = 1'b1;
        end
      end
      START: begin
        if (bit_valid) next_state = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_valid) begin
          take_data = 1'b1;
          if (bit_cnt == last_idx_r) next_state = pen_r ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_valid) begin
          take_par   = 1'b1;
          next_state = STOP;
        end
      end
      STOP: begin
        if (bit_valid) begin
          take_stop  = 1'b1;
          // A low stop bit means break or line fault: wait for the line to recover
          next_state = bit_val ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Parity the transmitter should have sent for the bits received so far
  always_comb begin
    exp_par = 1'b0;
    if (sticky_r)   exp_par = ~eps_r;
    else if (eps_r) exp_par = ^data_r;
    else            exp_par = ~^data_r;
  end

  // Frame datapath and the registered character/flag outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pen_r      <= 1'b0;
      eps_r      <= 1'b0;
      sticky_r   <= 1'b0;
      last_idx_r <= 3'd0;
      bit_cnt    <= 3'd0;
      data_r     <= 8'h00;
      par_err_r  <= 1'b0;
      zero_r     <= 1'b0;
      push       <= 1'b0;
      dout       <= 8'h00;
      pe         <= 1'b0;
      fe         <= 1'b0;
      bi         <= 1'b0;
    end else begin
      push <= take_stop;
      if (load_cfg) begin
        pen_r      <= pen;
        eps_r      <= eps;
        sticky_r   <= sticky_parity;
        last_idx_r <= 3'(wls_bits(wls) - 4'd1);
        bit_cnt    <= 3'd0;
        data_r     <= 8'h00;
        par_err_r  <= 1'b0;
        zero_r     <= 1'b1;
      end
      if (take_data) begin
        data_r[bit_cnt] <= bit_val;
        bit_cnt         <= bit_cnt + 3'd1;
        zero_r          <= zero_r & ~bit_val;
      end
      if (take_par) begin
        par_err_r <= (bit_val != exp_par);
        zero_r    <= zero_r & ~bit_val;
      end
      if (take_stop) begin
        dout <= data_r;
        pe   <= par_err_r;
        fe   <= ~bit_val;
        bi   <= zero_r & ~bit_val;
      end
    end
  end

  assign rx_busy   = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top: valid frames, parity/framing errors, break,
// false start glitch and reset in the middle of a frame.
module tb_uart_rx_top;

  localparam int DIV      = 4;           // clocks per baud_pulse
  localparam int OS       = 16;
  localparam int BIT_CLKS = DIV * OS;    // clocks per bit period

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_pulse = 1'b0;
  logic       rx = 1'b1;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sticky_parity = 1'b0;
  logic [1:0] wls = 2'b11;
  logic       push;
  logic [7:0] dout;
  logic       pe, fe, bi, rx_busy;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  // Push monitor
  int         push_cnt = 0;
  int         cyc = 0;
  int         push_cyc = 0;
  int         start_cyc = 0;
  logic [7:0] cap_dout;
  logic       cap_pe, cap_fe, cap_bi;

  uart_rx_top dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .rx            (rx),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .wls           (wls),
    .push          (push),
    .dout          (dout),
    .pe            (pe),
    .fe            (fe),
    .bi            (bi),
    .rx_busy       (rx_busy),
    .state_dbg     (state_dbg)
  );

  // Clock and free-running baud tick generator
  always #5 clk = ~clk;

  logic [1:0] div_cnt = 2'd0;
  always @(posedge clk) begin
    div_cnt    <= div_cnt + 2'd1;
    baud_pulse <= (div_cnt == 2'(DIV - 1));
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (push) begin
      push_cnt = push_cnt + 1;
      push_cyc = cyc;
      cap_dout = dout;
      cap_pe   = pe;
      cap_fe   = fe;
      cap_bi   = bi;
    end
  end

  // Reference parity for the masked data word
  function automatic logic calc_par(input logic [7:0] d, input logic e, input logic s);
    if (s)      return ~e;
    else if (e) return ^d;
    else        return ~^d;
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Start, data LSB first, optional parity, one stop bit; no trailing idle
  task automatic send_frame(input logic [7:0] d, input int nbits, input logic use_par,
                            input logic par_bit, input logic stop_bit);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (use_par) send_bit(par_bit);
    send_bit(stop_bit);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (push !== 1'b0)      begin errors++; $display("FAIL reset_push got=%b exp=0", push); end
    checks++; if (dout !== 8'h00)     begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if ({pe, fe, bi} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {pe, fe, bi}); end
    checks++; if (rx_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    rst = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_parity_ok;
    int p0, lat, k;
    logic pb;
    wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
    pb  = calc_par(8'h13, 1'b1, 1'b0);   // three ones, even parity -> 1
    p0  = push_cnt;
    send_frame(8'h13, 8, 1'b1, pb, 1'b1);
    send_bit(1'b1);
    checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL par_ok_pushes got=%0d exp=1", push_cnt - p0); end
    checks++; if (cap_dout !== 8'h13)  begin errors++; $display("FAIL par_ok_dout got=%h exp=13", cap_dout); end
    checks++; if ({cap_pe, cap_fe, cap_bi} !== 3'b000) begin errors++; $display("FAIL par_ok_flags got=%b exp=000", {cap_pe, cap_fe, cap_bi}); end
    checks++; if (rx_busy !== 1'b0)    begin errors++; $display("FAIL par_ok_busy got=%b exp=0", rx_busy); end
    // Push expected OS/2 + (1+8+1)*OS ticks after the start edge
    k   = OS / 2 + 10 * OS;
    lat = push_cyc - start_cyc;
    checks++; if (lat < DIV * k - 1 || lat > DIV * k + 6) begin errors++; $display("FAIL par_ok_latency got=%0d exp=%0d..%0d", lat, DIV * k - 1, DIV * k + 6); end
  endtask

  task automatic test_parity_err;
    int p0;
    logic pb;
    pb = ~calc_par(8'h13, 1'b1, 1'b0);
    p0 = push_cnt;
    send_frame(8'h13, 8, 1'b1, pb, 1'b1);
    send_bit(1'b1);
    checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL par_err_pushes got=%0d exp=1", push_cnt - p0); end
    checks++; if (cap_dout !== 8'h13)  begin errors++; $display("FAIL par_err_dout got=%h exp=13", cap_dout); end
    checks++; if (cap_pe !== 1'b1)     begin errors++; $display("FAIL par_err_pe got=%b exp=1", cap_pe); end
    checks++; if (cap_fe !== 1'b0)     begin errors++; $display("FAIL par_err_fe got=%b exp=0", cap_fe); end
  endtask

  task automatic test_framing;
    int p0;
    wls = 2'b00; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
    p0 = push_cnt;
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL frm_pushes got=%0d exp=1", push_cnt - p0); end
    checks++; if (cap_dout !== 8'h15)  begin errors++; $display("FAIL frm_dout got=%h exp=15", cap_dout); end
    checks++; if (cap_fe !== 1'b1)     begin errors++; $display("FAIL frm_fe got=%b exp=1", cap_fe); end
    checks++; if (cap_bi !== 1'b0)     begin errors++; $display("FAIL frm_bi got=%b exp=0", cap_bi); end
    checks++; if (state_dbg !== 3'd5)  begin errors++; $display("FAIL frm_wait_state got=%0d exp=5", state_dbg); end
    rx = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (rx_busy !== 1'b0)    begin errors++; $display("FAIL frm_release_busy got=%b exp=0", rx_busy); end
    send_bit(1'b1);
  endtask

  task automatic test_break;
    int p0;
    wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
    p0 = push_cnt;
    rx = 1'b0;
    repeat (3 * 11 * BIT_CLKS) @(negedge clk);
    checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL brk_pushes got=%0d exp=1", push_cnt - p0); end
    checks++; if (cap_dout !== 8'h00)  begin errors++; $display("FAIL brk_dout got=%h exp=00", cap_dout); end
    checks++; if (cap_bi !== 1'b1)     begin errors++; $display("FAIL brk_bi got=%b exp=1", cap_bi); end
    checks++; if (cap_fe !== 1'b1)     begin errors++; $display("FAIL brk_fe got=%b exp=1", cap_fe); end
    checks++; if (cap_pe !== 1'b0)     begin errors++; $display("FAIL brk_pe got=%b exp=0", cap_pe); end
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL brk_after_pushes got=%0d exp=1", push_cnt - p0); end
    checks++; if (rx_busy !== 1'b0)    begin errors++; $display("FAIL brk_after_busy got=%b exp=0", rx_busy); end
  endtask

  task automatic test_glitch;
    int p0;
    p0 = push_cnt;
    rx = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_busy !== 1'b1)    begin errors++; $display("FAIL glitch_start_busy got=%b exp=1", rx_busy); end
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (push_cnt - p0 !== 0) begin errors++; $display("FAIL glitch_pushes got=%0d exp=0", push_cnt - p0); end
    checks++; if (rx_busy !== 1'b0)    begin errors++; $display("FAIL glitch_busy got=%b exp=0", rx_busy); end
  endtask

  task automatic test_reset_mid_frame;
    int p0;
    logic [7:0] a5 = 8'hA5;
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
    p0 = push_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(a5[i]);
    rx = a5[3];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got=%b exp=0", rx_busy); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (push_cnt - p0 !== 0) begin errors++; $display("FAIL rstmid_no_push got=%0d exp=0", push_cnt - p0); end
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL rstmid_pushes got=%0d exp=1", push_cnt - p0); end
    checks++; if (cap_dout !== 8'h3C)  begin errors++; $display("FAIL rstmid_dout got=%h exp=3c", cap_dout); end
    checks++; if ({cap_pe, cap_fe, cap_bi} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got=%b exp=000", {cap_pe, cap_fe, cap_bi}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_parity_ok;
    test_parity_err;
    test_framing;
    test_break;
    test_glitch;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
